// File: rtl/frame_buf_mgr_if.sv
// Frame-event and buffer-address bundle between the capture/display control and
// frame_buf_mgr.
interface frame_buf_mgr_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned CNT_W  = 16
);
  logic              freeze;
  logic              wr_frame_start;
  logic              wr_frame_done;
  logic              rd_frame_start;
  logic [ADDR_W-1:0] wr_base_addr;
  logic [ADDR_W-1:0] rd_base_addr;
  logic              wr_busy;
  logic              rd_valid;
  logic              frame_write_done;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  repeat_cnt;

  modport master (
    output freeze, wr_frame_start, wr_frame_done, rd_frame_start,
    input  wr_base_addr, rd_base_addr, wr_busy, rd_valid, frame_write_done,
    input  drop_cnt, repeat_cnt
  );

  modport slave (
    input  freeze, wr_frame_start, wr_frame_done, rd_frame_start,
    output wr_base_addr, rd_base_addr, wr_busy, rd_valid, frame_write_done,
    output drop_cnt, repeat_cnt
  );
endinterface

// File: rtl/frame_buf_mgr.sv
// N-buffer DDR frame pointer manager: the writer never picks the buffer being displayed,
// the reader always takes the newest complete frame at vsync.
module frame_buf_mgr #(
  parameter int unsigned       NUM_BUF     = 3,
  parameter int unsigned       IDX_W       = 2,
  parameter int unsigned       ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] FRAME_WORDS = 24'h01FE00,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  frame_buf_mgr_if.slave  bus
);

  typedef enum logic [0:0] {StWIdle, StWAct} wr_state_e;

  wr_state_e         wr_state_q;
  logic [IDX_W-1:0]  wr_idx_q, rd_idx_q, latest_idx_q;
  logic              latest_valid_q, fresh_q, rd_valid_q;
  logic [ADDR_W-1:0] wr_base_q, rd_base_q;
  logic              wr_busy_q, rd_valid_out_q, done_pulse_q;
  logic [CNT_W-1:0]  drop_cnt_q, repeat_cnt_q;

  logic              done_fire, start_fire, fresh_mid, rd_take, rd_repeat;
  logic              latest_valid_d, rd_valid_d, fresh_d, sel_found;
  logic [IDX_W-1:0]  latest_idx_d, rd_idx_d, sel_idx;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + ADDR_W'(idx) * FRAME_WORDS;
  endfunction

  // Same-cycle ordering: writer completion, then reader vsync, then new writer frame.
  always_comb begin
    done_fire      = bus.wr_frame_done && (wr_state_q == StWAct);
    start_fire     = bus.wr_frame_start && !bus.freeze;
    latest_idx_d   = done_fire ? wr_idx_q : latest_idx_q;
    latest_valid_d = latest_valid_q | done_fire;
    fresh_mid      = fresh_q | done_fire;
    rd_take        = bus.rd_frame_start && fresh_mid;
    rd_repeat      = bus.rd_frame_start && !fresh_mid && rd_valid_q;
    rd_idx_d       = rd_take ? latest_idx_d : rd_idx_q;
    rd_valid_d     = rd_valid_q | rd_take;
    fresh_d        = fresh_mid & ~rd_take;

    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      if (!sel_found && !(rd_valid_d && rd_idx_d == IDX_W'(i)) &&
          !(NUM_BUF >= 3 && latest_valid_d && latest_idx_d == IDX_W'(i))) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q     <= StWIdle;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      latest_idx_q   <= '0;
      latest_valid_q <= 1'b0;
      fresh_q        <= 1'b0;
      rd_valid_q     <= 1'b0;
      wr_base_q      <= BASE_ADDR;
      rd_base_q      <= BASE_ADDR;
      wr_busy_q      <= 1'b0;
      rd_valid_out_q <= 1'b0;
      done_pulse_q   <= 1'b0;
      drop_cnt_q     <= '0;
      repeat_cnt_q   <= '0;
    end else begin
      if (start_fire) begin
        wr_state_q <= StWAct;
        wr_idx_q   <= sel_idx;
      end else if (done_fire) begin
        wr_state_q <= StWIdle;
      end
      latest_idx_q   <= latest_idx_d;
      latest_valid_q <= latest_valid_d;
      fresh_q        <= fresh_d;
      rd_idx_q       <= rd_idx_d;
      rd_valid_q     <= rd_valid_d;

      // A second completed frame while the previous one is still unseen drops it.
      if (done_fire && fresh_q && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      if (rd_repeat && repeat_cnt_q != '1) repeat_cnt_q <= repeat_cnt_q + CNT_W'(1);

      wr_base_q      <= addr_of(wr_idx_q);
      rd_base_q      <= addr_of(rd_idx_q);
      wr_busy_q      <= (wr_state_q == StWAct);
      rd_valid_out_q <= rd_valid_q;
      done_pulse_q   <= done_fire;
    end
  end

  assign bus.wr_base_addr     = wr_base_q;
  assign bus.rd_base_addr     = rd_base_q;
  assign bus.wr_busy          = wr_busy_q;
  assign bus.rd_valid         = rd_valid_out_q;
  assign bus.frame_write_done = done_pulse_q;
  assign bus.drop_cnt         = drop_cnt_q;
  assign bus.repeat_cnt       = repeat_cnt_q;

endmodule
